// File: rtl/trivium_pkg.sv
// trivium_pkg: shared widths, default timeout and state encoding for the Trivium serialiser
package trivium_pkg;
  localparam int TRIV_KEY_W = 80;
  localparam int TRIV_IV_W = 80;
  localparam int TRIV_INIT_TIMEOUT = 2048;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_SHIFT_KEY = 3'd1;
  localparam state_t ST_SHIFT_IV = 3'd2;
  localparam state_t ST_WAIT_INIT = 3'd3;
  localparam state_t ST_WORD_IDLE = 3'd4;
  localparam state_t ST_SHIFT_WORD = 3'd5;
  localparam state_t ST_OUT_HOLD = 3'd6;
  localparam state_t ST_END = 3'd7;
endpackage

// File: rtl/trivium_bit_shifter.sv
// trivium_bit_shifter: loadable shift register, LSB end out by default, MSB end out when TRIVIUM_SER_MSB_FIRST_EN is defined
module trivium_bit_shifter #(
  parameter int W = 80
) (
  input logic clk,
  input logic rst,
  input logic load,
  input logic [W-1:0] din,
  input logic shift,
  input logic sin,
  output logic [W-1:0] q,
  output logic sout
);
  logic [W-1:0] shifted;
`ifdef TRIVIUM_SER_MSB_FIRST_EN
  assign shifted = {q[W-2:0], sin};
  assign sout = q[W-1];
`else
  assign shifted = {sin, q[W-1:1]};
  assign sout = q[0];
`endif
  // Parallel load takes priority over shifting; reset clears the register immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= load ? din : shift ? shifted : q;
endmodule

// File: rtl/trivium_ser_ctrl.sv
// trivium_ser_ctrl: serialises key/IV/words into trivium_top and reassembles its output; bit order set by TRIVIUM_SER_MSB_FIRST_EN
module trivium_ser_ctrl
  import trivium_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int INIT_TIMEOUT = TRIV_INIT_TIMEOUT
) (
  input logic clk_i,
  input logic rst_i,
  input logic [TRIV_KEY_W-1:0] key_i,
  input logic [TRIV_IV_W-1:0] iv_i,
  input logic init_i,
  input logic [WORD_W-1:0] word_i,
  input logic word_valid_i,
  output logic word_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic word_valid_o,
  input logic word_ready_i,
  input logic end_i,
  output logic busy_o,
  output logic err_o,
  output logic core_dat_o,
  output logic core_get_dat_o,
  output logic core_ld_keys_o,
  output logic core_end_o,
  input logic core_dat_i,
  input logic core_ready_i
);
  localparam int CNT_W = $clog2(WORD_W > TRIV_KEY_W ? WORD_W : TRIV_KEY_W);
  localparam int TMO_W = $clog2(INIT_TIMEOUT + 1);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [TMO_W-1:0] wait_cnt;
  logic key_bit, iv_bit, word_bit, out_unused;
  logic [TRIV_KEY_W-1:0] key_unused;
  logic [TRIV_IV_W-1:0] iv_unused;
  logic [WORD_W-1:0] word_unused;
  logic init_go, word_go, key_last, iv_last, word_last;
  assign init_go = state == ST_IDLE && init_i;
  assign word_go = state == ST_WORD_IDLE && !end_i && word_valid_i;
  assign key_last = cnt == CNT_W'(TRIV_KEY_W - 1);
  assign iv_last = cnt == CNT_W'(TRIV_IV_W - 1);
  assign word_last = cnt == CNT_W'(WORD_W - 1);
  trivium_bit_shifter #(.W(TRIV_KEY_W)) u_key (
    .clk(clk_i), .rst(rst_i), .load(init_go), .din(key_i),
    .shift(state == ST_SHIFT_KEY), .sin(1'b0), .q(key_unused), .sout(key_bit)
  );
  trivium_bit_shifter #(.W(TRIV_IV_W)) u_iv (
    .clk(clk_i), .rst(rst_i), .load(init_go), .din(iv_i),
    .shift(state == ST_SHIFT_IV), .sin(1'b0), .q(iv_unused), .sout(iv_bit)
  );
  trivium_bit_shifter #(.W(WORD_W)) u_word (
    .clk(clk_i), .rst(rst_i), .load(word_go), .din(word_i),
    .shift(state == ST_SHIFT_WORD), .sin(1'b0), .q(word_unused), .sout(word_bit)
  );
  trivium_bit_shifter #(.W(WORD_W)) u_out (
    .clk(clk_i), .rst(rst_i), .load(1'b0), .din('0),
    .shift(state == ST_SHIFT_WORD), .sin(core_dat_i), .q(word_o), .sout(out_unused)
  );
  // Session sequencing: key, IV, init wait with timeout, then word shifts until end; ready beats timeout
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= ST_IDLE;
      cnt <= '0;
      wait_cnt <= '0;
      err_o <= 1'b0;
    end else
      case (state)
        ST_IDLE:
          if (init_i) begin
            state <= ST_SHIFT_KEY;
            cnt <= '0;
            err_o <= 1'b0;
          end
        ST_SHIFT_KEY: begin
          cnt <= key_last ? '0 : cnt + 1'b1;
          if (key_last) state <= ST_SHIFT_IV;
        end
        ST_SHIFT_IV: begin
          cnt <= iv_last ? '0 : cnt + 1'b1;
          wait_cnt <= '0;
          if (iv_last) state <= ST_WAIT_INIT;
        end
        ST_WAIT_INIT:
          if (core_ready_i) state <= ST_WORD_IDLE;
          else if (wait_cnt == TMO_W'(INIT_TIMEOUT - 1)) begin
            err_o <= 1'b1;
            state <= ST_IDLE;
          end else wait_cnt <= wait_cnt + 1'b1;
        ST_WORD_IDLE:
          if (end_i) state <= ST_END;
          else if (word_valid_i) begin
            state <= ST_SHIFT_WORD;
            cnt <= '0;
          end
        ST_SHIFT_WORD: begin
          cnt <= cnt + 1'b1;
          if (word_last) state <= ST_OUT_HOLD;
        end
        ST_OUT_HOLD: if (word_ready_i) state <= ST_WORD_IDLE;
        default: state <= ST_IDLE;
      endcase
  // Core strobes and handshakes decoded from the registered state
  always_comb begin
    core_get_dat_o = state == ST_SHIFT_KEY || state == ST_SHIFT_IV || state == ST_SHIFT_WORD;
    core_dat_o = state == ST_SHIFT_KEY ? key_bit : state == ST_SHIFT_IV ? iv_bit :
                 state == ST_SHIFT_WORD ? word_bit : 1'b0;
    core_ld_keys_o = state == ST_SHIFT_IV && iv_last;
    core_end_o = state == ST_END;
    word_valid_o = state == ST_OUT_HOLD;
    word_ready_o = state == ST_WORD_IDLE && !end_i;
    busy_o = state != ST_IDLE;
  end
endmodule

// File: tb/tb_trivium_ser_ctrl.sv
// tb_trivium_ser_ctrl: randomized self-checking bench for trivium_ser_ctrl against a bit-order reference model
module tb_trivium_ser_ctrl;
  localparam int W = 32;
  localparam int TMO = 16;
  logic clk_i = 1'b0;
  logic rst_i, init_i, word_valid_i, word_ready_i, end_i, core_ready_i;
  logic [79:0] key_i, iv_i;
  logic [W-1:0] word_i, word_o;
  logic word_ready_o, word_valid_o, busy_o, err_o;
  logic core_dat_o, core_get_dat_o, core_ld_keys_o, core_end_o, core_dat_i;
  logic loop_en, ext_bit;
  logic [W+7:0] outs;
  int checks = 0;
  int errors = 0;
  assign core_dat_i = loop_en ? core_dat_o : ext_bit;
  assign outs = {word_ready_o, word_o, word_valid_o, busy_o, err_o, core_dat_o, core_get_dat_o, core_ld_keys_o, core_end_o};
  always #5 clk_i = ~clk_i;
  trivium_ser_ctrl #(.WORD_W(W), .INIT_TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .key_i(key_i), .iv_i(iv_i), .init_i(init_i),
    .word_i(word_i), .word_valid_i(word_valid_i), .word_ready_o(word_ready_o),
    .word_o(word_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .end_i(end_i), .busy_o(busy_o), .err_o(err_o), .core_dat_o(core_dat_o),
    .core_get_dat_o(core_get_dat_o), .core_ld_keys_o(core_ld_keys_o),
    .core_end_o(core_end_o), .core_dat_i(core_dat_i), .core_ready_i(core_ready_i)
  );
  function automatic logic [79:0] rand80();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[79:0];
  endfunction
  task automatic test_reset();
    rst_i = 1; init_i = 0; word_valid_i = 0; word_ready_i = 0; end_i = 0; core_ready_i = 0;
    key_i = '0; iv_i = '0; word_i = '0; loop_en = 0; ext_bit = 0;
    @(negedge clk_i);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset outs got %h want 0", outs); end
    rst_i = 0;
    @(negedge clk_i);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL post-reset idle outs got %h want 0", outs); end
  endtask
  task automatic test_init(input logic [79:0] key, input logic [79:0] iv, input int ready_at, input int abort_at);
    logic exp_bit;
    key_i = key; iv_i = iv; init_i = 1;
    @(negedge clk_i);
    for (int k = 1; k <= 160; k++) begin
`ifdef TRIVIUM_SER_MSB_FIRST_EN
      exp_bit = k <= 80 ? key[80-k] : iv[160-k];
`else
      exp_bit = k <= 80 ? key[k-1] : iv[k-81];
`endif
      checks++;
      if ({core_get_dat_o, core_dat_o, core_ld_keys_o, core_end_o, busy_o, err_o, word_ready_o, word_valid_o} !==
          {1'b1, exp_bit, k == 160, 5'b01000}) begin
        errors++;
        $display("FAIL init shift k=%0d got get=%b dat=%b ld=%b end=%b busy=%b err=%b rdy=%b vld=%b want dat=%b ld=%b",
                 k, core_get_dat_o, core_dat_o, core_ld_keys_o, core_end_o, busy_o, err_o, word_ready_o, word_valid_o,
                 exp_bit, k == 160);
      end
      if (k == abort_at) begin
        rst_i = 1;
        #1;
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL async reset mid-shift got %h want 0", outs); end
        @(negedge clk_i);
        rst_i = 0; init_i = 0; end_i = 0;
        return;
      end
      init_i = 1'($urandom); end_i = 1'($urandom); key_i = rand80(); iv_i = rand80();
      @(negedge clk_i);
    end
    init_i = 0; end_i = 0;
    for (int c = 1; c <= TMO; c++) begin
      checks++;
      if ({busy_o, core_get_dat_o, core_ld_keys_o, err_o, word_ready_o} !== 5'b10000) begin
        errors++;
        $display("FAIL wait_init c=%0d got busy=%b get=%b ld=%b err=%b rdy=%b want 10000",
                 c, busy_o, core_get_dat_o, core_ld_keys_o, err_o, word_ready_o);
      end
      if (c == ready_at) core_ready_i = 1;
      @(negedge clk_i);
      core_ready_i = 0;
      if (c == ready_at) begin
        checks++;
        if ({busy_o, word_ready_o, err_o} !== 3'b110) begin
          errors++;
          $display("FAIL init ready c=%0d got busy=%b rdy=%b err=%b want 110", c, busy_o, word_ready_o, err_o);
        end
        return;
      end
    end
    checks++;
    if ({busy_o, err_o} !== 2'b01) begin
      errors++;
      $display("FAIL init timeout got busy=%b err=%b want busy=0 err=1", busy_o, err_o);
    end
  endtask
  task automatic test_word(input logic [W-1:0] w, input logic loop, input int hold);
    logic [W-1:0] exp_w;
    logic exp_bit, b;
    loop_en = loop; exp_w = '0;
    checks++;
    if (word_ready_o !== 1'b1) begin errors++; $display("FAIL word_ready idle got %b want 1", word_ready_o); end
    word_i = w; word_valid_i = 1;
    @(negedge clk_i);
    for (int k = 1; k <= W; k++) begin
`ifdef TRIVIUM_SER_MSB_FIRST_EN
      exp_bit = w[W-k];
`else
      exp_bit = w[k-1];
`endif
      checks++;
      if ({core_get_dat_o, core_dat_o, word_ready_o, word_valid_o, busy_o} !== {1'b1, exp_bit, 3'b001}) begin
        errors++;
        $display("FAIL word shift k=%0d got get=%b dat=%b rdy=%b vld=%b busy=%b want dat=%b",
                 k, core_get_dat_o, core_dat_o, word_ready_o, word_valid_o, busy_o, exp_bit);
      end
      b = loop ? exp_bit : 1'($urandom);
      ext_bit = b;
`ifdef TRIVIUM_SER_MSB_FIRST_EN
      exp_w[W-k] = b;
`else
      exp_w[k-1] = b;
`endif
      word_valid_i = 1'($urandom); word_i = $urandom; end_i = 1'($urandom); init_i = 1'($urandom);
      @(negedge clk_i);
    end
    word_valid_i = 0; end_i = 0; init_i = 0;
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if ({word_valid_o, word_ready_o, core_get_dat_o, word_o} !== {3'b100, exp_w}) begin
        errors++;
        $display("FAIL out_hold h=%0d got vld=%b rdy=%b get=%b word=%h want vld=1 word=%h",
                 h, word_valid_o, word_ready_o, core_get_dat_o, word_o, exp_w);
      end
      word_ready_i = h == hold;
      @(negedge clk_i);
    end
    word_ready_i = 0;
    checks++;
    if ({word_valid_o, word_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL word release got vld=%b rdy=%b want 01", word_valid_o, word_ready_o);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) test_word($urandom, 1'b0, 0);
  endtask
  task automatic test_end();
    end_i = 1; word_valid_i = 1; word_i = $urandom;
    #1;
    checks++;
    if (word_ready_o !== 1'b0) begin errors++; $display("FAIL end vs word ready got %b want 0", word_ready_o); end
    @(negedge clk_i);
    end_i = 0; word_valid_i = 0;
    checks++;
    if ({core_end_o, busy_o, core_get_dat_o, word_ready_o} !== 4'b1100) begin
      errors++;
      $display("FAIL end strobe got end=%b busy=%b get=%b rdy=%b want 1100", core_end_o, busy_o, core_get_dat_o, word_ready_o);
    end
    @(negedge clk_i);
    checks++;
    if ({core_end_o, busy_o, core_get_dat_o, word_ready_o} !== 4'b0000) begin
      errors++;
      $display("FAIL end done got end=%b busy=%b get=%b rdy=%b want 0000", core_end_o, busy_o, core_get_dat_o, word_ready_o);
    end
  endtask
  task automatic test_timeout();
    test_init(rand80(), rand80(), 0, 0);
    test_init(rand80(), rand80(), TMO, 0);
    test_word($urandom, 1'b0, 1);
    test_end();
  endtask
  task automatic test_reset_mid();
    test_init(rand80(), rand80(), 3, 121);
    test_init(rand80(), rand80(), 3, 0);
    test_word($urandom, 1'b1, 2);
    test_end();
  endtask
  initial begin
    test_reset();
    test_init(80'h8000_0000_0000_0000_0001, 80'h0, 1, 0);
    test_word(32'hDEADBEEF, 1'b1, 5);
    test_word(32'h0000_0001, 1'b1, 0);
    for (int i = 0; i < 4; i++) test_word($urandom, 1'b0, int'($urandom_range(0, 3)));
    test_back_to_back();
    test_end();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
